paged_bcd_display: RTL and testbench

- Generalised successor to the fixed three-phase 7-segment page rotator.
- Snapshots a binary value and converts it to BCD with a sequential shift-add-3 (double-dabble) engine.
- Presents the digits one page at a time, rotating on an internal dwell counter, with a blank separator page between passes.
- Drives BCD_2_7Seg instances and a page-label decoder in the top level; replaces the slowClock-driven rotation with a single-clock enable scheme.

---
 rtl/paged_bcd_display.sv | 216 +++++++++++++++++++++
 tb/tb_paged_bcd_display.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/paged_bcd_display.sv
// paged_bcd_display
// Snapshots a binary value, converts it to BCD with a sequential
// shift-add-3 (double-dabble) engine, then shows the digits one page
// at a time. Pages rotate on a dwell counter in the order
// NPAGES (blank separator) -> NPAGES-1 (most significant) -> ... -> 0.
// A new snapshot is taken on every tick that enters the separator page,
// so all pages of one pass come from the same value.
// Optional build macro: LEADING_ZERO_BLANK_EN -- when defined, leading
// zero digits are stored as 4'hF (blank) when a conversion completes;
// digit 0 is never blanked.

module paged_bcd_display #(
  parameter  int DATA_W      = 36,
  parameter  int DIGITS      = 9,
  parameter  int PAGE_DIGITS = 3,
  parameter  int DWELL       = 25000000,
  localparam int NPAGES      = (DIGITS + PAGE_DIGITS - 1) / PAGE_DIGITS,
  localparam int PG_W        = $clog2(NPAGES + 1)
) (
  input  logic                     CLOCK_50,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     freeze,
  output logic [4*PAGE_DIGITS-1:0] page_bcd,
  output logic [PG_W-1:0]          page_idx,
  output logic                     page_tick,
  output logic                     busy,
  output logic                     ovf
);

  localparam int BCD_W  = DIGITS * 4;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int DW_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int SLOTS  = NPAGES * PAGE_DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 load_en;
  logic                 shift_en;
  logic                 done_en;

  logic [DATA_W-1:0]    bin_sr;
  logic [BCD_W-1:0]     scratch;
  logic [BCD_W-1:0]     adj;
  logic [BCD_W-1:0]     dabble_nxt;
  logic                 ovf_scratch;
  logic [CNT_W-1:0]     bit_cnt;
  logic [BCD_W-1:0]     result;
  logic [BCD_W-1:0]     result_nxt;

  logic [DW_W-1:0]      dwell;
  logic                 tick_now;
  logic                 snap_req;
  logic [PG_W-1:0]      page_after;
  logic [4*PAGE_DIGITS-1:0] page_fill;
  logic [3:0]           digit_arr [SLOTS];

  // A tick happens when the dwell counter reaches its last count and the
  // display is not frozen; entering the separator page requests a snapshot.
  assign tick_now   = !freeze && (dwell == DW_W'(DWELL - 1));
  assign page_after = (page_idx == '0) ? PG_W'(NPAGES) : (page_idx - PG_W'(1));
  assign snap_req   = tick_now && (page_idx == '0);

  // Conversion FSM state register; reset restarts a conversion right away.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Conversion FSM next-state and datapath strobes.
  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    done_en   = 1'b0;
    case (state)
      IDLE: begin
        if (snap_req) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (!freeze) begin
          load_en   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done_en   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

  // Add-3 correction on every nibble that is 5 or more, ahead of the shift.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
      end
    end
  end

  // The binary MSB enters BCD bit 0; the top BCD bit falls off and feeds
  // the sticky overflow flag.
  assign dabble_nxt = {adj[BCD_W-2:0], bin_sr[DATA_W-1]};

`ifdef LEADING_ZERO_BLANK_EN
  logic seen_nz;

  // Blank leading zeros above the most significant non-zero digit.
  always_comb begin
    result_nxt = scratch;
    seen_nz    = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (!seen_nz && (scratch[i*4 +: 4] == 4'd0)) begin
        result_nxt[i*4 +: 4] = 4'hF;
      end else begin
        seen_nz = 1'b1;
      end
    end
  end
`else
  assign result_nxt = scratch;
`endif

  // Conversion datapath: capture, iterate, and publish the finished result.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      bin_sr      <= '0;
      scratch     <= '0;
      ovf_scratch <= 1'b0;
      bit_cnt     <= '0;
      result      <= '0;
      ovf         <= 1'b0;
      busy        <= 1'b0;
    end else if (load_en) begin
      bin_sr      <= data_in;
      scratch     <= '0;
      ovf_scratch <= 1'b0;
      bit_cnt     <= '0;
      busy        <= 1'b1;
    end else if (shift_en) begin
      bin_sr      <= bin_sr << 1;
      scratch     <= dabble_nxt;
      ovf_scratch <= ovf_scratch | adj[BCD_W-1];
      bit_cnt     <= bit_cnt + CNT_W'(1);
    end else if (done_en) begin
      result      <= result_nxt;
      ovf         <= ovf_scratch;
      busy        <= 1'b0;
    end
  end

  // Digit slots of every page; slots past the last real digit are blank.
  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    if (k < DIGITS) begin : g_real
      assign digit_arr[k] = result[k*4 +: 4];
    end else begin : g_pad
      assign digit_arr[k] = 4'hF;
    end
  end

  // Contents of the page about to be shown; the separator stays all blank.
  always_comb begin
    page_fill = '1;
    for (int p = 0; p < NPAGES; p++) begin
      if (page_after == PG_W'(p)) begin
        for (int j = 0; j < PAGE_DIGITS; j++) begin
          page_fill[j*4 +: 4] = digit_arr[p*PAGE_DIGITS + j];
        end
      end
    end
  end

  // Dwell counter and page rotation; freeze holds the whole display.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      dwell     <= '0;
      page_idx  <= PG_W'(NPAGES);
      page_bcd  <= '1;
      page_tick <= 1'b0;
    end else begin
      page_tick <= 1'b0;
      if (tick_now) begin
        dwell     <= '0;
        page_tick <= 1'b1;
        page_idx  <= page_after;
        page_bcd  <= page_fill;
      end else if (!freeze) begin
        dwell <= dwell + DW_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_paged_bcd_display.sv
// tb_paged_bcd_display
// Scoreboard bench: stimulus pushes the expected page sequence of each
// snapshot into a queue, and a monitor pops and compares on every
// page_tick. Expected pages come from decimal arithmetic on the value.

module tb_paged_bcd_display;

  localparam int DATA_W      = 16;
  localparam int DIGITS      = 4;
  localparam int PAGE_DIGITS = 3;
  localparam int DWELL       = 40;
  localparam int NPAGES      = (DIGITS + PAGE_DIGITS - 1) / PAGE_DIGITS;
  localparam int PG_W        = $clog2(NPAGES + 1);

  logic                     CLOCK_50 = 1'b0;
  logic                     rst      = 1'b1;
  logic [DATA_W-1:0]        data_in  = '0;
  logic                     freeze   = 1'b0;
  logic [4*PAGE_DIGITS-1:0] page_bcd;
  logic [PG_W-1:0]          page_idx;
  logic                     page_tick;
  logic                     busy;
  logic                     ovf;

  paged_bcd_display #(
    .DATA_W(DATA_W),
    .DIGITS(DIGITS),
    .PAGE_DIGITS(PAGE_DIGITS),
    .DWELL(DWELL)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .rst(rst),
    .data_in(data_in),
    .freeze(freeze),
    .page_bcd(page_bcd),
    .page_idx(page_idx),
    .page_tick(page_tick),
    .busy(busy),
    .ovf(ovf)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int                       idx;
    logic [4*PAGE_DIGITS-1:0] bcd;
    bit                       chk_ovf;
    bit                       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   spacing    = 0;
  exp_t mon_e;

  function automatic longint pow10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Digit k of what the display should show for value v.
  function automatic logic [3:0] refDigit(input longint v, input int k);
    longint m = v % pow10(DIGITS);
    if (k >= DIGITS) return 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && (m / pow10(k)) == 0) return 4'hF;
`endif
    return 4'((m / pow10(k)) % 10);
  endfunction

  function automatic logic [4*PAGE_DIGITS-1:0] refPage(input longint v, input int p);
    logic [4*PAGE_DIGITS-1:0] r = '1;
    if (p < NPAGES) begin
      for (int j = 0; j < PAGE_DIGITS; j++) r[j*4 +: 4] = refDigit(v, p*PAGE_DIGITS + j);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: wait expired at %0t", name, $time);
  endtask

  // Drive a new value and queue the pass it will produce once snapshotted.
  task automatic applyStimulus(input longint v);
    exp_t e;
    data_in = DATA_W'(v);
    for (int p = NPAGES - 1; p >= 0; p--) begin
      e.idx     = p;
      e.bcd     = refPage(v, p);
      e.chk_ovf = (p == NPAGES - 1);
      e.ovf     = (v >= pow10(DIGITS));
      exp_q.push_back(e);
    end
    e.idx     = NPAGES;
    e.bcd     = '1;
    e.chk_ovf = 1'b0;
    e.ovf     = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic checkResetState();
    checkOutput("reset_page_idx", page_idx, NPAGES);
    checkOutput("reset_page_bcd", page_bcd, {4*PAGE_DIGITS{1'b1}});
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ovf", ovf, 0);
    checkOutput("reset_page_tick", page_tick, 0);
  endtask

  // Count cycles from reset release until busy drops after the conversion.
  task automatic measureLatency();
    int  n    = 0;
    bit  seen = 0;
    bit  ok   = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLOCK_50);
      n++;
      if (n == 1) checkOutput("busy_rise", busy, 1);
      if (busy) seen = 1;
      else if (seen) begin
        ok = 1;
        break;
      end
    end
    if (ok) checkOutput("conv_latency", n, DATA_W + 2);
    else timeoutFail("conv_latency");
  endtask

  task automatic waitPage(input int target);
    bit ok = 0;
    for (int i = 0; i < 4*DWELL*(NPAGES+1); i++) begin
      @(negedge CLOCK_50);
      if (page_tick && page_idx == PG_W'(target)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeoutFail("wait_page");
  endtask

  // Monitor: every page change is compared against the head of the queue.
  always @(posedge CLOCK_50) begin
    #1;
    if (rst) begin
      spacing = 0;
    end else begin
      if (!freeze) spacing++;
      if (page_tick) begin
        checkOutput("tick_spacing", spacing, DWELL);
        spacing = 0;
        if (exp_q.size() == 0) begin
          timeoutFail("unexpected_tick");
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("page_idx", page_idx, mon_e.idx);
          checkOutput("page_bcd", page_bcd, mon_e.bcd);
          if (mon_e.chk_ovf) checkOutput("ovf", ovf, mon_e.ovf);
        end
      end
    end
  end

  initial begin
    longint vals[$] = '{999, 65535, 9999, 0};
    logic [PG_W-1:0]          hold_idx;
    logic [4*PAGE_DIGITS-1:0] hold_bcd;
    bit ok;

    for (int i = 0; i < 4; i++) vals.push_back(longint'($urandom_range(0, 65535)));

    repeat (3) @(negedge CLOCK_50);
    checkResetState();
    applyStimulus(12345);
    rst = 1'b0;
    measureLatency();

    foreach (vals[i]) begin
      waitPage(NPAGES - 1);
      repeat ($urandom_range(2, 30)) @(negedge CLOCK_50);
      applyStimulus(vals[i]);
    end

    // Freeze part way through page 0 and check the display holds.
    waitPage(0);
    repeat ($urandom_range(3, 20)) @(negedge CLOCK_50);
    hold_idx = page_idx;
    hold_bcd = page_bcd;
    freeze   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLOCK_50);
      checkOutput("freeze_tick", page_tick, 0);
      checkOutput("freeze_idx", page_idx, hold_idx);
      checkOutput("freeze_bcd", page_bcd, hold_bcd);
    end
    freeze = 1'b0;

    // Reset in the middle of the conversion started by the separator page.
    waitPage(NPAGES);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      if (busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeoutFail("wait_busy");
    repeat (7) @(negedge CLOCK_50);
    rst = 1'b1;
    @(negedge CLOCK_50);
    checkResetState();
    exp_q.delete();
    applyStimulus(longint'($urandom_range(0, 65535)));
    rst = 1'b0;
    measureLatency();

    ok = 0;
    for (int i = 0; i < 4*DWELL*(NPAGES+1); i++) begin
      @(negedge CLOCK_50);
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeoutFail("queue_drain");
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
